// File: rtl/shift194_seq.sv
// Command sequencer for one DM74LS194: turns clear/load/shift/rotate commands into S1/S0, data and clear strobes.
// Optional SHIFT194_SEQ_AUTO_SCAN_EN adds an auto_scan input that issues a periodic one-step ROTL while idle.
module shift194_seq #(
  parameter int CNT_W    = 4
`ifdef SHIFT194_SEQ_AUTO_SCAN_EN
  ,
  parameter int SCAN_DIV = 1000
`endif
) (
  input  logic             clk,
  input  logic             CR,
`ifdef SHIFT194_SEQ_AUTO_SCAN_EN
  input  logic             auto_scan,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [3:0]       cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [3:0]       q,
  output logic             sr_clr_n,
  output logic             sr_s1,
  output logic             sr_s0,
  output logic [3:0]       sr_par,
  output logic             sr_sl,
  output logic             sr_sr,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_NOP, OP_CLEAR, OP_LOAD, OP_SHR, OP_SHL, OP_ROTR, OP_ROTL, OP_JOHN
  } op_e;

  state_e           state, state_nxt;
  op_e              op_q, op_nxt, op_in;
  logic [3:0]       data_q, data_nxt;
  logic [CNT_W-1:0] rem, rem_nxt;
  logic             scan_q, scan_nxt;
  logic             clr_n_q;
  logic             scan_tick;
  logic             unused_q_mid;

  // Only QA and QD feed back into the serial inputs.
  assign unused_q_mid = ^q[2:1];
  assign op_in        = op_e'(cmd_op);

`ifdef SHIFT194_SEQ_AUTO_SCAN_EN
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  logic [DIV_W-1:0] div;
  logic             div_wrap;

  assign div_wrap  = (div == DIV_W'(SCAN_DIV - 1));
  assign scan_tick = auto_scan && div_wrap;

  always_ff @(posedge clk) begin
    if (CR || div_wrap) div <= '0;
    else                div <= div + DIV_W'(1);
  end
`else
  assign scan_tick = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    op_nxt    = op_q;
    data_nxt  = data_q;
    rem_nxt   = rem;
    scan_nxt  = scan_q;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          // A NOP is consumed here and also swallows a coincident scan tick.
          if (op_in != OP_NOP) begin
            op_nxt   = op_in;
            data_nxt = cmd_data;
            scan_nxt = 1'b0;
            if (op_in == OP_CLEAR || op_in == OP_LOAD) begin
              rem_nxt   = CNT_W'(1);
              state_nxt = S_EXEC;
            end else if (cmd_cnt == '0) begin
              rem_nxt   = '0;
              state_nxt = S_DONE;
            end else begin
              rem_nxt   = cmd_cnt;
              state_nxt = S_EXEC;
            end
          end
        end else if (scan_tick) begin
          op_nxt    = OP_ROTL;
          data_nxt  = '0;
          rem_nxt   = CNT_W'(1);
          scan_nxt  = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        rem_nxt = rem - CNT_W'(1);
        if (rem == CNT_W'(1)) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (CR) begin
      state   <= S_IDLE;
      op_q    <= OP_NOP;
      data_q  <= '0;
      rem     <= '0;
      scan_q  <= 1'b0;
      clr_n_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      op_q    <= op_nxt;
      data_q  <= data_nxt;
      rem     <= rem_nxt;
      scan_q  <= scan_nxt;
      // Clear drives the 194's asynchronous input, so it comes straight from a flop.
      clr_n_q <= !(state_nxt == S_EXEC && op_nxt == OP_CLEAR);
    end
  end

  always_comb begin
    sr_s1  = 1'b0;
    sr_s0  = 1'b0;
    sr_par = '0;
    sr_sl  = 1'b0;
    sr_sr  = 1'b0;
    if (state == S_EXEC) begin
      case (op_q)
        OP_LOAD: begin sr_s1 = 1'b1; sr_s0 = 1'b1; sr_par = data_q; end
        OP_SHR:  begin sr_s0 = 1'b1; sr_sr = data_q[0]; end
        OP_SHL:  begin sr_s1 = 1'b1; sr_sl = data_q[0]; end
        OP_ROTR: begin sr_s0 = 1'b1; sr_sr = q[0]; end
        OP_ROTL: begin sr_s1 = 1'b1; sr_sl = q[3]; end
        OP_JOHN: begin sr_s0 = 1'b1; sr_sr = ~q[0]; end
        default: ;
      endcase
    end
  end

  assign sr_clr_n  = clr_n_q;
  assign cmd_ready = (state == S_IDLE) && !CR;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE) && !scan_q;

endmodule

// File: tb/tb_shift194_seq.sv
// Directed bench for shift194_seq driving a behavioural 74LS194 (async clear, sync modes).
module tb_shift194_seq;

  logic       clk = 1'b0;
  logic       CR;
  logic       auto_scan;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] cmd_cnt;
  logic [3:0] q;
  logic       sr_clr_n, sr_s1, sr_s0, sr_sl, sr_sr, busy, done;
  logic [3:0] sr_par;
  logic [3:0] exp_seq [0:15];
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  shift194_seq #(
    .CNT_W(4)
`ifdef SHIFT194_SEQ_AUTO_SCAN_EN
    , .SCAN_DIV(4)
`endif
  ) dut (
    .clk(clk),
    .CR(CR),
`ifdef SHIFT194_SEQ_AUTO_SCAN_EN
    .auto_scan(auto_scan),
`endif
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_data(cmd_data),
    .cmd_cnt(cmd_cnt),
    .q(q),
    .sr_clr_n(sr_clr_n),
    .sr_s1(sr_s1),
    .sr_s0(sr_s0),
    .sr_par(sr_par),
    .sr_sl(sr_sl),
    .sr_sr(sr_sr),
    .busy(busy),
    .done(done)
  );

  // 74LS194: q = {QA,QB,QC,QD}; right shift moves SR into QA.
  always @(posedge clk or negedge sr_clr_n) begin
    if (!sr_clr_n) q <= 4'b0000;
    else begin
      case ({sr_s1, sr_s0})
        2'b01:   q <= {sr_sr, q[3:1]};
        2'b10:   q <= {q[2:0], sr_sl};
        2'b11:   q <= sr_par;
        default: q <= q;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] data, input logic [3:0] cnt);
    cmd_op    = op;
    cmd_data  = data;
    cmd_cnt   = cnt;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  // Issue a command taking n steps in the given mode; q is checked against exp_seq after each 194 edge.
  task automatic run(input logic [2:0] op, input logic [3:0] data, input int n, input logic [1:0] mode);
    send(op, data, 4'(n));
    for (int i = 0; i < n; i++) begin
      chk("busy", busy, 1);
      chk("mode", {sr_s1, sr_s0}, mode);
      if (mode == 2'd3) chk("par", sr_par, data);
      else              chk("par_zero", sr_par, 0);
      if (mode != 2'd1) chk("sr_unused", sr_sr, 0);
      if (mode != 2'd2) chk("sl_unused", sr_sl, 0);
      chk("clr_n", sr_clr_n, (op == 3'd1) ? 0 : 1);
      chk("ready_exec", cmd_ready, 0);
      step();
      chk("q", q, exp_seq[i]);
    end
    chk("done", done, 1);
    chk("done_mode", {sr_s1, sr_s0}, 0);
    chk("ready_done", cmd_ready, 0);
    step();
    chk("done_single", done, 0);
    chk("ready_idle", cmd_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    CR = 1'b1; auto_scan = 1'b0; cmd_valid = 1'b0;
    cmd_op = 3'd0; cmd_data = 4'd0; cmd_cnt = 4'd0;
    step();
    step();
    chk("rst_clr_n", sr_clr_n, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mode", {sr_s1, sr_s0}, 0);
    chk("rst_par", sr_par, 0);
    chk("rst_q", q, 0);
    CR = 1'b0;
    step();
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_clr_n", sr_clr_n, 1);

    send(3'd0, 4'hF, 4'd3);
    chk("nop_busy", busy, 0);
    chk("nop_done", done, 0);
    chk("nop_ready", cmd_ready, 1);
    chk("nop_q", q, 0);

    exp_seq[0] = 4'b1000;
    run(3'd2, 4'b1000, 1, 2'b11);

    exp_seq[0] = 4'b0100; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0001;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0100;
    run(3'd5, 4'b0000, 5, 2'b01);

    exp_seq[0] = 4'b0000;
    run(3'd1, 4'b0000, 1, 2'b00);

    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0011; exp_seq[2] = 4'b0111;
    run(3'd4, 4'b0001, 3, 2'b10);

    exp_seq[0] = 4'b0000;
    run(3'd1, 4'b0000, 1, 2'b00);

    exp_seq[0] = 4'b1000; exp_seq[1] = 4'b1100; exp_seq[2] = 4'b1110; exp_seq[3] = 4'b1111;
    exp_seq[4] = 4'b0111; exp_seq[5] = 4'b0011; exp_seq[6] = 4'b0001; exp_seq[7] = 4'b0000;
    run(3'd7, 4'b0000, 8, 2'b01);

    exp_seq[0] = 4'b1000; exp_seq[1] = 4'b1100;
    run(3'd3, 4'b0001, 2, 2'b01);

    // Shift with a zero count completes at once without touching the register.
    send(3'd3, 4'b0001, 4'd0);
    chk("cnt0_done", done, 1);
    chk("cnt0_mode", {sr_s1, sr_s0}, 0);
    chk("cnt0_q", q, 4'b1100);
    step();
    chk("cnt0_idle", cmd_ready, 1);

    exp_seq[0] = 4'b1001;
    run(3'd2, 4'b1001, 1, 2'b11);

    // A held request waits out the running ROTL and is taken the cycle after done.
    exp_seq[0] = 4'b0011; exp_seq[1] = 4'b0110; exp_seq[2] = 4'b1100; exp_seq[3] = 4'b1001;
    send(3'd6, 4'b0000, 4'd4);
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_data = 4'b0101; cmd_cnt = 4'd0;
    for (int i = 0; i < 4; i++) begin
      chk("held_ready", cmd_ready, 0);
      chk("rotl_mode", {sr_s1, sr_s0}, 2'b10);
      step();
      chk("rotl_q", q, exp_seq[i]);
    end
    chk("held_done", done, 1);
    chk("held_ready_done", cmd_ready, 0);
    step();
    chk("held_ready_idle", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    chk("held_load_mode", {sr_s1, sr_s0}, 2'b11);
    chk("held_load_par", sr_par, 4'b0101);
    step();
    chk("held_load_q", q, 4'b0101);
    chk("held_load_done", done, 1);
    step();

    // Reset during the third ROTR step aborts the command and clears the 194.
    send(3'd5, 4'b0000, 4'd10);
    step();
    chk("abort_q1", q, 4'b1010);
    step();
    chk("abort_q2", q, 4'b0101);
    CR = 1'b1;
    step();
    chk("abort_q", q, 0);
    chk("abort_clr_n", sr_clr_n, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    CR = 1'b0;
    step();
    chk("abort_ready", cmd_ready, 1);
    chk("abort_no_done", done, 0);
    chk("abort_clr_rel", sr_clr_n, 1);
    step();
    chk("abort_no_done2", done, 0);

`ifdef SHIFT194_SEQ_AUTO_SCAN_EN
    exp_seq[0] = 4'b0001;
    run(3'd2, 4'b0001, 1, 2'b11);
    exp_seq[0] = 4'b0010; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b1000; exp_seq[3] = 4'b0001;
    auto_scan = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] prev;
      int         waited;
      prev = q;
      waited = 0;
      while (q == prev && waited < 10) begin
        chk("scan_no_done", done, 0);
        step();
        waited++;
      end
      chk("scan_q", q, exp_seq[k]);
    end
    auto_scan = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
